// File: rtl/mem_arb_if.sv
// Bundles the three requester ports and the shared memory port of mem_arb.
// The arbiter uses the slave view; requesters and the memory model use the master view.
interface mem_arb_if #(
    parameter int AW = 16,
    parameter int DW = 32
);
    logic [2:0]      req;
    logic [2:0]      we;
    logic [3*AW-1:0] addr;
    logic [3*DW-1:0] wdata;
    logic [2:0]      done;
    logic            err;
    logic [DW-1:0]   rdata;
    logic [1:0]      gnt_id;
    logic            busy;
    logic            mem_req;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_rdata;
    logic            mem_ack;

    modport slave (
        input  req, we, addr, wdata, mem_rdata, mem_ack,
        output done, err, rdata, gnt_id, busy,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req, we, addr, wdata, mem_rdata, mem_ack,
        input  done, err, rdata, gnt_id, busy,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arb.sv
// Round-robin arbiter for the shared memory port: fetch, load/store and debug
// requesters, one outstanding transaction, ack-or-timeout completion.
module mem_arb #(
    parameter int AW      = 16,
    parameter int DW      = 32,
    parameter int TIMEOUT = 15
) (
    input  logic     clk,
    input  logic     rst,
    mem_arb_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t          state_q;
    logic [1:0]      rr_last_q;
    logic [7:0]      cnt_q;
    logic [2:0]      done_q;
    logic            err_q;
    logic [DW-1:0]   rdata_q;
    logic [1:0]      gnt_q;
    logic            busy_q;
    logic            mem_req_q;
    logic            mem_we_q;
    logic [AW-1:0]   mem_addr_q;
    logic [DW-1:0]   mem_wdata_q;

    // Scan order starts just after the last winner: cand[0] is highest priority.
    logic [1:0]      cand [3];
    logic [2:0]      hit;
    logic            gnt_vld_d;
    logic [1:0]      gnt_d;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_scan
            logic [2:0] sum;
            assign sum       = {1'b0, rr_last_q} + 3'(gi + 1);
            assign cand[gi]  = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
            assign hit[gi]   = bus.req[cand[gi]];
        end
    endgenerate

    always_comb begin
        gnt_vld_d = |hit;
        gnt_d     = cand[2];
        if (hit[0]) begin
            gnt_d = cand[0];
        end else if (hit[1]) begin
            gnt_d = cand[1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_last_q   <= 2'd2;
            cnt_q       <= '0;
            done_q      <= '0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            gnt_q       <= '0;
            busy_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= '0;
                    err_q  <= 1'b0;
                    if (gnt_vld_d) begin
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= bus.we[gnt_d];
                        mem_addr_q  <= bus.addr[gnt_d*AW +: AW];
                        mem_wdata_q <= bus.wdata[gnt_d*DW +: DW];
                        gnt_q       <= gnt_d;
                        rr_last_q   <= gnt_d;
                        cnt_q       <= '0;
                        busy_q      <= 1'b1;
                        state_q     <= WAIT;
                    end else begin
                        mem_req_q <= 1'b0;
                    end
                end
                WAIT: begin
                    // An ack on the final timeout edge still counts as success.
                    if (bus.mem_ack) begin
                        rdata_q   <= mem_we_q ? '0 : bus.mem_rdata;
                        mem_req_q <= 1'b0;
                        err_q     <= 1'b0;
                        done_q    <= 3'b001 << gnt_q;
                        state_q   <= DONE;
                    end else if (cnt_q == CNT_LAST) begin
                        rdata_q   <= '0;
                        mem_req_q <= 1'b0;
                        err_q     <= 1'b1;
                        done_q    <= 3'b001 << gnt_q;
                        state_q   <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                DONE: begin
                    done_q  <= '0;
                    err_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.rdata     = rdata_q;
    assign bus.gnt_id    = gnt_q;
    assign bus.busy      = busy_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arb.sv
// Bench for mem_arb: vector table plus hand sequences, a memory model with
// programmable ack delay, and a scoreboard queue of expected completions.
module tb_mem_arb;

    localparam int AW      = 16;
    localparam int DW      = 32;
    localparam int TIMEOUT = 15;

    typedef struct {
        logic [2:0]  req;
        logic [2:0]  we;
        logic [47:0] addr;
        logic [31:0] wd;
        int          delay;
        logic [1:0]  gnt;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    logic clk;
    logic rst;
    int   ack_delay;
    logic spur_ack;
    int   wc;
    int   n_chk;
    int   n_fail;
    vec_t sb [$];
    vec_t tbl [13];

    mem_arb_if #(.AW(AW), .DW(DW)) bus ();

    mem_arb #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [15:0] a);
        return (a == 16'h0010) ? 32'hDEADBEEF : {~a, a};
    endfunction

    // Memory model: acks once mem_req has been seen for more than ack_delay cycles.
    always @(negedge clk) begin
        if (bus.mem_req) wc <= wc + 1;
        else             wc <= 0;
    end
    assign bus.mem_ack   = (bus.mem_req && (wc > ack_delay)) || spur_ack;
    assign bus.mem_rdata = bus.mem_ack ? memf(bus.mem_addr) : 32'hBAD0BAD0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic [2:0] r, input logic [2:0] w,
                                 input logic [15:0] a0, input logic [15:0] a1,
                                 input logic [15:0] a2, input logic [31:0] wd,
                                 input int d, input logic [1:0] g, input logic e,
                                 input logic [31:0] rd);
        vec_t v;
        v.req   = r;
        v.we    = w;
        v.addr  = {a2, a1, a0};
        v.wd    = wd;
        v.delay = d;
        v.gnt   = g;
        v.err   = e;
        v.rdata = rd;
        return v;
    endfunction

    task automatic run_txn(input vec_t v, input int drop_at);
        int          req_hi;
        int          first_hi;
        bit          stable;
        bit          got;
        logic [15:0] ea;
        logic [31:0] ewd;
        logic        ewe;
        vec_t        e;
        @(negedge clk);
        chk("idle_gap", {61'd0, bus.busy, bus.mem_req, |bus.done}, 64'd0);
        bus.req   = v.req;
        bus.we    = v.we;
        bus.addr  = v.addr;
        bus.wdata = {v.wd + 32'd2, v.wd + 32'd1, v.wd};
        ack_delay = v.delay;
        sb.push_back(v);
        ea       = v.addr[v.gnt*16 +: 16];
        ewd      = v.wd + 32'(v.gnt);
        ewe      = v.we[v.gnt];
        stable   = 1'b1;
        got      = 1'b0;
        req_hi   = 0;
        first_hi = -1;
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(negedge clk);
            if (bus.done != 3'b000) begin
                got = 1'b1;
                break;
            end
            if (bus.mem_req) begin
                if (first_hi < 0) first_hi = cyc;
                req_hi++;
                if (bus.mem_addr !== ea || bus.mem_we !== ewe || bus.mem_wdata !== ewd)
                    stable = 1'b0;
                if (drop_at > 0 && req_hi == drop_at) bus.req = 3'b000;
            end
        end
        chk("done_seen", {63'd0, got}, 64'd1);
        if (!got) begin
            void'(sb.pop_front());
            return;
        end
        e = sb.pop_front();
        chk("done_onehot", {61'd0, bus.done}, {61'd0, 3'b001 << e.gnt});
        chk("gnt_id", {62'd0, bus.gnt_id}, {62'd0, e.gnt});
        chk("err", {63'd0, bus.err}, {63'd0, e.err});
        chk("rdata", {32'd0, bus.rdata}, {32'd0, e.rdata});
        chk("busy_in_done", {63'd0, bus.busy}, 64'd1);
        chk("mem_stable", {63'd0, stable}, 64'd1);
        chk("req_latency", 64'(first_hi), 64'd0);
        chk("mem_req_cycles", 64'(req_hi), e.err ? 64'(TIMEOUT) : 64'(e.delay + 1));
        $display("txn port=%0d err=%0b rdata=%h mem_req_cycles=%0d", bus.gnt_id, bus.err,
                 bus.rdata, req_hi);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  g_save;
        logic [31:0] r_save;
        n_chk     = 0;
        n_fail    = 0;
        wc        = 0;
        spur_ack  = 1'b0;
        ack_delay = 0;
        bus.req   = '0;
        bus.we    = '0;
        bus.addr  = '0;
        bus.wdata = '0;
        rst       = 1'b0;

        tbl[0]  = mkv(3'b111, 3'b000, 16'h0100, 16'h0200, 16'h0300, 32'h0, 0, 2'd0, 1'b0, 32'hFEFF0100);
        tbl[1]  = mkv(3'b111, 3'b000, 16'h0100, 16'h0200, 16'h0300, 32'h0, 0, 2'd1, 1'b0, 32'hFDFF0200);
        tbl[2]  = mkv(3'b111, 3'b000, 16'h0100, 16'h0200, 16'h0300, 32'h0, 0, 2'd2, 1'b0, 32'hFCFF0300);
        tbl[3]  = mkv(3'b111, 3'b000, 16'h0100, 16'h0200, 16'h0300, 32'h0, 0, 2'd0, 1'b0, 32'hFEFF0100);
        tbl[4]  = mkv(3'b111, 3'b000, 16'h0100, 16'h0200, 16'h0300, 32'h0, 0, 2'd1, 1'b0, 32'hFDFF0200);
        tbl[5]  = mkv(3'b111, 3'b000, 16'h0100, 16'h0200, 16'h0300, 32'h0, 0, 2'd2, 1'b0, 32'hFCFF0300);
        tbl[6]  = mkv(3'b001, 3'b000, 16'h0010, 16'h0000, 16'h0000, 32'h0, 2, 2'd0, 1'b0, 32'hDEADBEEF);
        tbl[7]  = mkv(3'b010, 3'b010, 16'h0000, 16'h0020, 16'h0000, 32'h12345677, 3, 2'd1, 1'b0, 32'h0);
        tbl[8]  = mkv(3'b100, 3'b000, 16'h0000, 16'h0000, 16'h0300, 32'h0, 15, 2'd2, 1'b1, 32'h0);
        tbl[9]  = mkv(3'b100, 3'b000, 16'h0000, 16'h0000, 16'h0304, 32'h0, 1, 2'd2, 1'b0, 32'hFCFB0304);
        tbl[10] = mkv(3'b001, 3'b000, 16'h0040, 16'h0000, 16'h0000, 32'h0, 14, 2'd0, 1'b0, 32'hFFBF0040);
        tbl[11] = mkv(3'b101, 3'b000, 16'h0044, 16'h0000, 16'h0308, 32'h0, 0, 2'd2, 1'b0, 32'hFCF70308);
        tbl[12] = mkv(3'b101, 3'b001, 16'h0044, 16'h0000, 16'h0308, 32'hCAFEF00D, 0, 2'd0, 1'b0, 32'h0);

        #3 rst = 1'b1;
        #1;
        chk("reset_outputs", {31'd0, bus.done, bus.err, bus.gnt_id, bus.busy, bus.mem_req,
                              bus.mem_we, bus.mem_addr, 5'd0},
            64'd0);
        chk("reset_rdata", {32'd0, bus.rdata}, 64'd0);
        chk("reset_wdata", {32'd0, bus.mem_wdata}, 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) run_txn(tbl[i], 0);

        // Requester withdraws its request mid-WAIT; completion must still arrive.
        run_txn(mkv(3'b100, 3'b000, 16'h0, 16'h0, 16'h030C, 32'h0, 4, 2'd2, 1'b0, 32'hFCF3030C), 2);

        // Spurious ack while idle must not start or complete anything.
        @(negedge clk);
        bus.req = 3'b000;
        g_save  = bus.gnt_id;
        r_save  = bus.rdata;
        spur_ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("spur_idle", {61'd0, bus.busy, bus.mem_req, |bus.done}, 64'd0);
        end
        spur_ack = 1'b0;
        chk("spur_gnt_hold", {62'd0, bus.gnt_id}, {62'd0, g_save});
        chk("spur_rdata_hold", {32'd0, bus.rdata}, {32'd0, r_save});

        // Reset in the middle of a never-acked transaction.
        bus.req   = 3'b001;
        bus.addr  = {16'h0, 16'h0, 16'h0050};
        ack_delay = 255;
        repeat (3) @(negedge clk);
        chk("pre_rst_wait", {62'd0, bus.busy, bus.mem_req}, 64'd3);
        rst = 1'b1;
        #1;
        chk("rst_async_drop", {61'd0, bus.busy, bus.mem_req, |bus.done}, 64'd0);
        bus.req = 3'b000;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst_no_done", {61'd0, bus.done}, 64'd0);
        end
        run_txn(mkv(3'b110, 3'b000, 16'h0, 16'h0210, 16'h0310, 32'h0, 0, 2'd1, 1'b0, 32'hFDEF0210), 0);

        @(negedge clk);
        chk("final_idle", {60'd0, bus.done, bus.busy}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
